i2s_tdm_transmitter: RTL
========================

Name: i2s_tdm_transmitter

Overview:
Parametrised serial audio transmitter that generates sclk and ws from mclk and shifts multi-channel PCM frames out on sd_tx. It is the successor to the fixed two-channel 16-bit I2S transmitter and adds the following:
- Configurable sample width, slot width, channel count and sclk divide.
- Valid/ready frame input with a one-frame holding buffer.
- Underrun detection.
It sits between the DAW mixer output and the codec DAC pins.

Parameters:
WIDTH, 16, sample bits per channel (8..32).
CHANNELS, 2, channels per frame (even, 2..8).
SLOT_BITS, 32, sclk periods per channel slot (>= WIDTH).
SCLK_DIV, 4, mclk cycles per sclk period (even, >= 2).

Ports:
mclk  input  1  master clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
s_data  input  CHANNELS*WIDTH  frame; channel c at s_data[c*WIDTH +: WIDTH], channel 0 = left.
s_valid  input  1  s_data valid.
s_ready  output  1  holding buffer empty; frame accepted on s_valid && s_ready.
sclk  output  1  bit clock, mclk/SCLK_DIV, 50% duty.
ws  output  1  word select / frame sync.
sd_tx  output  1  serial data, MSB first.
underrun  output  1  one-mclk pulse when a frame boundary finds the holding buffer empty.

Behaviour:
- Constants: FRAME = CHANNELS*SLOT_BITS bits.
- Counters:
  - div_cnt runs 0..SCLK_DIV-1 and wraps.
  - bit_cnt b runs 0..FRAME-1 and advances when div_cnt wraps.
- sclk is registered: 0 for div_cnt < SCLK_DIV/2, 1 otherwise.
- Bit boundary: the mclk edge where div_cnt wraps SCLK_DIV-1 -> 0 (sclk falling). sd_tx and ws update only on this edge. Receivers sample on sclk rising.
- Data for bit b:
  - slot s = b / SLOT_BITS, position p = b % SLOT_BITS.
  - sd_tx = shadow[s][WIDTH-1-p] if p < WIDTH, else 0 (zero padding).
- ws (I2S, one-bit lead): ws = 1 iff ((b+1) mod FRAME) >= FRAME/2. ws therefore changes one bit before the MSB of the first right-half slot and before the MSB of slot 0.
- Buffering:
  - hold register plus hold_full flag; s_ready = !hold_full.
  - The shadow register feeds the shifter.
  - Frame boundary: the bit boundary where b wraps FRAME-1 -> 0.
    - If hold_full: shadow <= hold and hold_full clears.
    - Else: shadow <= 0 and underrun pulses for that mclk cycle.
- Simultaneous events:
  - Accept and frame boundary in the same cycle with hold empty: the new frame goes to hold, shadow is zeroed and underrun still pulses.
  - Accept with hold full is impossible, because s_ready = 0.
- Reset values (asynchronous, immediate): sclk=0, ws=0, sd_tx=0, s_ready=1, underrun=0, div_cnt=0, bit_cnt=FRAME-1, hold/shadow=0, hold_full=0.
- After rst_n rises, the first bit period outputs sd_tx=0 and ws=0. The first frame boundary occurs SCLK_DIV mclk cycles after release. A frame accepted within the first SCLK_DIV-1 cycles therefore avoids underrun.
- Reset mid-frame aborts the frame. Timing restarts as described above.
- Latency: from accept, with hold empty at mid-frame, to the MSB on sd_tx is the remainder of the current frame plus 0 bits.

Optional Feature:
I2S_TX_TDM_EN
- Defined: DSP/TDM framing. ws = 1 only for b = FRAME-1, a one-sclk pulse one bit before the slot 0 MSB; otherwise 0. Slot data mapping is unchanged.
- Undefined: standard I2S 50% ws as described in Behaviour.

Test Plan:
1. Hold rst_n low 10 cycles -> sclk=0, ws=0, sd_tx=0, s_ready=1, underrun=0 throughout; release -> sclk toggles every 2 mclk (SCLK_DIV=4).
2. Defaults, s_data={16'hFFFF,16'h1111} accepted after reset -> next frame sd_tx: bits 0..15 = 0x1111, 16..31 = 0, 32..47 = 0xFFFF, 48..63 = 0. ws=1 for b = 31..62; s_ready=1 again after the frame boundary.
3. No further s_valid -> following frame is all zeros on sd_tx, underrun high exactly 1 mclk at the boundary, 256 mclk after the previous boundary.
4. Two frames offered back-to-back (0xAAAA/0x5555, then 0x1234/0x4321) -> second held with s_ready=0 until the boundary; both transmitted in order with no underrun.
5. rst_n pulsed low at b=20 of a loaded frame -> outputs return to reset values within the same cycle; hold cleared; first post-reset frame is zeros with underrun unless refilled.
6. I2S_TX_TDM_EN, CHANNELS=4, SLOT_BITS=16, slots 0xA5A5/0x5A5A/0x0F0F/0xF0F0 -> sd_tx carries the slots in order, ws single-sclk pulse at b=63 only.

Source files
------------

// File: rtl/i2s_tdm_transmitter.sv
// Parametrised I2S / TDM serial audio transmitter with a one-frame holding buffer.
// Define I2S_TX_TDM_EN for DSP/TDM framing (single-sclk ws pulse before slot 0).
module i2s_tdm_transmitter #(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 2,
    parameter int SLOT_BITS = 32,
    parameter int SCLK_DIV  = 4
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic [CHANNELS*WIDTH-1:0]    s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic                         sclk,
    output logic                         ws,
    output logic                         sd_tx,
    output logic                         underrun
);

    localparam int FRAME = CHANNELS * SLOT_BITS;
    localparam int DW    = $clog2(SCLK_DIV);
    localparam int BW    = $clog2(FRAME);
    localparam int PW    = $clog2(SLOT_BITS);
    localparam int SW    = $clog2(CHANNELS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(SCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME - 1);
    localparam logic [BW-1:0] WS_RISE   = BW'(FRAME / 2 - 1);
    localparam logic [PW-1:0] POS_LAST  = PW'(SLOT_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);

    logic [DW-1:0]               r_div;
    logic [BW-1:0]               r_bit;
    logic [PW-1:0]               r_pos;
    logic [SW-1:0]               r_slot;
    logic                        r_sclk;
    logic                        r_ws;
    logic                        r_sd;
    logic                        r_underrun;
    logic                        r_hold_full;
    logic [CHANNELS*WIDTH-1:0]   r_hold;
    logic [CHANNELS*WIDTH-1:0]   r_shadow;

    logic                        w_div_wrap;
    logic [DW-1:0]               w_div_nxt;
    logic                        w_frame_bnd;
    logic [BW-1:0]               w_bit_nxt;
    logic                        w_pos_last;
    logic [PW-1:0]               w_pos_nxt;
    logic [SW-1:0]               w_slot_nxt;
    logic [CHANNELS*WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]            w_word;
    logic                        w_sd_nxt;
    logic                        w_ws_nxt;
    logic                        w_accept;

    always_comb begin
        w_div_wrap  = (r_div == DIV_LAST);
        w_div_nxt   = w_div_wrap ? '0 : r_div + 1'b1;
        w_frame_bnd = w_div_wrap && (r_bit == BIT_LAST);
        w_bit_nxt   = (r_bit == BIT_LAST) ? '0 : r_bit + 1'b1;
        w_pos_last  = (r_pos == POS_LAST);
        w_pos_nxt   = w_pos_last ? '0 : r_pos + 1'b1;
        w_slot_nxt  = !w_pos_last ? r_slot :
                      ((r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1);
        w_accept    = s_valid && !r_hold_full;

        // At a frame boundary the shifter must already see the frame being loaded.
        w_src = w_frame_bnd ? (r_hold_full ? r_hold : '0) : r_shadow;

        w_word = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (w_slot_nxt == SW'(c)) w_word = w_src[c*WIDTH +: WIDTH];
        end

        // Positions at or beyond WIDTH match nothing and shift out padding zeros.
        w_sd_nxt = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (w_pos_nxt == PW'(i)) w_sd_nxt = w_word[WIDTH-1-i];
        end

`ifdef I2S_TX_TDM_EN
        w_ws_nxt = (w_bit_nxt == BIT_LAST);
`else
        w_ws_nxt = (w_bit_nxt >= WS_RISE) && (w_bit_nxt != BIT_LAST);
`endif
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_div       <= '0;
            r_bit       <= BIT_LAST;
            r_pos       <= POS_LAST;
            r_slot      <= SLOT_LAST;
            r_sclk      <= 1'b0;
            r_ws        <= 1'b0;
            r_sd        <= 1'b0;
            r_underrun  <= 1'b0;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_shadow    <= '0;
        end else begin
            r_div      <= w_div_nxt;
            r_sclk     <= (w_div_nxt >= DIV_HALF);
            r_underrun <= 1'b0;
            if (w_div_wrap) begin
                r_bit  <= w_bit_nxt;
                r_pos  <= w_pos_nxt;
                r_slot <= w_slot_nxt;
                r_sd   <= w_sd_nxt;
                r_ws   <= w_ws_nxt;
            end
            if (w_frame_bnd) begin
                if (r_hold_full) begin
                    r_shadow    <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_shadow   <= '0;
                    r_underrun <= 1'b1;
                end
            end
            // Accept is only possible with hold empty, so this never collides with the load above.
            if (w_accept) begin
                r_hold      <= s_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign s_ready  = !r_hold_full;
    assign sclk     = r_sclk;
    assign ws       = r_ws;
    assign sd_tx    = r_sd;
    assign underrun = r_underrun;

endmodule
